// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: sequences fetch/decode/execute states
// and produces registered per-state control signals plus op-decoded side outputs.
module multicycle_controller #(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  state_t cur;
  ctrl_t  ctrl;

  function automatic state_t next_state(input state_t s, input logic [6:0] o);
    case (s)
      S_FETCH:  return S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: return S_MEMADR;
          OP_R:         return S_EXECUTER;
          OP_I:         return S_EXECUTEI;
          OP_BEQ:       return S_BEQ;
          OP_JAL:       return S_JAL;
          default:      return S_FETCH;
        endcase
      end
      S_MEMADR:   return (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  return S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      return S_ALUWB;
      default:    return S_FETCH;
    endcase
  endfunction

  // Control word for the state being entered, so outputs line up with state.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic known_op(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL) || (o == OP_NOP);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      ctrl <= ctrl_for(S_FETCH);
    end else begin
      cur  <= next_state(cur, op);
      ctrl <= ctrl_for(next_state(cur, op));
    end
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign pc_write   = ctrl.pc_update | (ctrl.branch & zero);
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign state      = cur;
  assign illegal    = TRAP_ILLEGAL && (cur == S_DECODE) && !known_op(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed then random instruction
// streams checked against an instruction-level model of state sequences and outputs.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [3:0] state;

  int vectors;
  int miscompares;
  int seq_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .imm_src(imm_src), .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit is_listed(input logic [6:0] o);
    return o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
  endfunction

  // State visits of one instruction, FETCH inclusive.
  function automatic void build_seq(input logic [6:0] o);
    seq_q.delete();
    seq_q.push_back(0);
    seq_q.push_back(1);
    case (o)
      7'h03: begin seq_q.push_back(2); seq_q.push_back(3); seq_q.push_back(4); end
      7'h23: begin seq_q.push_back(2); seq_q.push_back(5); end
      7'h33: begin seq_q.push_back(6); seq_q.push_back(7); end
      7'h13: begin seq_q.push_back(8); seq_q.push_back(7); end
      7'h6F: begin seq_q.push_back(9); seq_q.push_back(7); end
      7'h63: seq_q.push_back(10);
      default: ;
    endcase
  endfunction

  // {pc_write, ir_write, adr_src, mem_write, reg_write, a, b, alu_op, result_src, imm_src, illegal}
  function automatic logic [15:0] expected_word(input int st, input logic [6:0] o, input logic z);
    logic       pcw, irw, adr, mw, rw, ill;
    logic [1:0] a, b, aop, rs, imm;
    pcw = (st == 0) || (st == 9) || (st == 10 && z);
    irw = (st == 0);
    adr = (st == 3) || (st == 5);
    mw  = (st == 5);
    rw  = (st == 4) || (st == 7);
    a   = (st == 1 || st == 9) ? 2'b01 : (st inside {2, 6, 8, 10}) ? 2'b10 : 2'b00;
    b   = (st == 0 || st == 9) ? 2'b10 : (st inside {1, 2, 8}) ? 2'b01 : 2'b00;
    aop = (st == 6 || st == 8) ? 2'b10 : (st == 10) ? 2'b01 : 2'b00;
    rs  = (st == 0) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
    imm = (o == 7'h23) ? 2'b01 : (o == 7'h63) ? 2'b10 : (o == 7'h6F) ? 2'b11 : 2'b00;
    ill = (st == 1) && !is_listed(o);
    return {pcw, irw, adr, mw, rw, a, b, aop, rs, imm, ill};
  endfunction

  task automatic check_output(input int st, input string tag);
    logic [15:0] obs, exp_w;
    exp_w = expected_word(st, op, zero);
    obs = {pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a,
           alu_src_b, alu_op, result_src, imm_src, illegal};
    vectors++;
    assert (state === 4'(st)) else begin
      miscompares++;
      $error("[TB] FAIL %s state: observed=%0d expected=%0d", tag, state, st);
    end
    vectors++;
    assert (obs === exp_w) else begin
      miscompares++;
      $error("[TB] FAIL %s controls: observed=%h expected=%h (state %0d op %h zero %b)",
             tag, obs, exp_w, st, op, zero);
    end
  endtask

  task automatic apply_stimulus(input int st, input logic [6:0] o, input logic z,
                                input logic rst, input string tag);
    @(negedge clk);
    op    = o;
    zero  = z;
    reset = rst;
    #1;
    check_output(st, tag);
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset during that step.
  task automatic run_instr(input logic [6:0] o, input logic bz, input int abort_at,
                           input string tag);
    logic [6:0] drive_op;
    logic       z;
    build_seq(o);
    for (int k = 0; k < seq_q.size(); k++) begin
      drive_op = (seq_q[k] == 1 || seq_q[k] == 2) ? o : 7'($urandom);
      z = (seq_q[k] == 10) ? bz : 1'($urandom);
      apply_stimulus(seq_q[k], drive_op, z, (k == abort_at), tag);
      if (k == abort_at) break;
    end
  endtask

  initial begin
    logic [6:0] legal_ops[8];
    logic [6:0] o;
    int ab;
    legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00, 7'h7F};
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    op = 7'h00;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    apply_stimulus(0, 7'h00, 1'b0, 1'b1, "reset_hold");

    run_instr(7'h03, 1'b0, -1, "lw");
    run_instr(7'h23, 1'b0, -1, "sw");
    run_instr(7'h63, 1'b1, -1, "beq_taken");
    run_instr(7'h63, 1'b0, -1, "beq_not_taken");
    run_instr(7'h6F, 1'b0, -1, "jal");
    run_instr(7'h7F, 1'b0, -1, "illegal_op");
    run_instr(7'h00, 1'b0, -1, "nop");
    run_instr(7'h13, 1'b0, -1, "alu_imm");
    run_instr(7'h33, 1'b0, 2, "alu_reg_reset");
    run_instr(7'h33, 1'b0, -1, "alu_reg");

    for (int n = 0; n < 300; n++) begin
      o  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(o, 1'($urandom), ab, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
